uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 119 +++++++++++
 tb/tb_uart_tx_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Two-source packet scheduler for a UART transmitter.
// Each packet pops one 16-bit word and emits {header, msb, lsb} as a byte stream.
module uart_tx_sched #(
    parameter int unsigned RD_LAT = 2,
    parameter logic [7:0]  HDR_A  = 8'hA5,
    parameter logic [7:0]  HDR_B  = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a_data,
    input  logic        a_empty,
    output logic        a_re,
    input  logic [15:0] b_data,
    input  logic        b_empty,
    output logic        b_re,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic        tx_busy,
    output logic [1:0]  grant,
    output logic [15:0] pkt_count
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        HDR,
        MSB,
        LSB
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

    state_t      state;
    logic [2:0]  wait_cnt;
    logic [15:0] data_q;
    logic        last_b;
    logic        pick_b;
    logic        any_ready;

    // Round-robin: a lone requester always wins, a tie goes to the source not served last.
    always_comb begin
        any_ready = !a_empty || !b_empty;
        if (b_empty)
            pick_b = 1'b0;
        else if (a_empty)
            pick_b = 1'b1;
        else
            pick_b = !last_b;
    end

    // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the data register is reset too; it is a single word, not a memory array.
            state         <= IDLE;
            wait_cnt      <= '0;
            data_q        <= '0;
            last_b        <= 1'b1;
            a_re          <= 1'b1;
            b_re          <= 1'b1;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            grant         <= 2'b00;
            pkt_count     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!tx_busy && any_ready) begin
                        grant <= pick_b ? 2'b10 : 2'b01;
                        a_re  <= pick_b;
                        b_re  <= !pick_b;
                        state <= READ;
                    end
                end
                READ: begin
                    a_re     <= 1'b1;
                    b_re     <= 1'b1;
                    wait_cnt <= WAIT_INIT;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        data_q        <= grant[1] ? b_data : a_data;
                        m_axis_tdata  <= grant[1] ? HDR_B : HDR_A;
                        m_axis_tvalid <= 1'b1;
                        state         <= HDR;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                HDR: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= data_q[15:8];
                        state        <= MSB;
                    end
                end
                MSB: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= data_q[7:0];
                        state        <= LSB;
                    end
                end
                LSB: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        pkt_count     <= pkt_count + 16'd1;
                        last_b        <= grant[1];
                        grant         <= 2'b00;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: small FIFO models with RD_LAT read latency feed both sources.
module tb_uart_tx_sched;

    localparam int RD_LAT = 2;

    logic        clk;
    logic        rst;
    logic [15:0] a_data;
    logic        a_empty;
    logic        a_re;
    logic [15:0] b_data;
    logic        b_empty;
    logic        b_re;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        tx_busy;
    logic [1:0]  grant;
    logic [15:0] pkt_count;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_sched #(.RD_LAT(RD_LAT), .HDR_A(8'hA5), .HDR_B(8'h5A)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_data       (a_data),
        .a_empty      (a_empty),
        .a_re         (a_re),
        .b_data       (b_data),
        .b_empty      (b_empty),
        .b_re         (b_re),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .tx_busy      (tx_busy),
        .grant        (grant),
        .pkt_count    (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source FIFO models: a pop on a low re sampled at posedge yields data RD_LAT cycles later.
    logic [15:0] a_mem [16];
    logic [15:0] b_mem [16];
    int a_wr = 0, a_rd = 0, a_pops = 0;
    int b_wr = 0, b_rd = 0, b_pops = 0;
    logic [RD_LAT-1:0]       a_pv = '0, b_pv = '0;
    logic [RD_LAT-1:0][15:0] a_pd = '0, b_pd = '0;
    int re_viol = 0;

    assign a_empty = (a_wr == a_rd);
    assign b_empty = (b_wr == b_rd);
    assign a_data  = a_pv[RD_LAT-1] ? a_pd[RD_LAT-1] : 16'hDEAD;
    assign b_data  = b_pv[RD_LAT-1] ? b_pd[RD_LAT-1] : 16'hBEEF;

    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) begin
            a_pv[i] <= a_pv[i-1];
            a_pd[i] <= a_pd[i-1];
            b_pv[i] <= b_pv[i-1];
            b_pd[i] <= b_pd[i-1];
        end
        a_pv[0] <= !a_re && (a_wr != a_rd);
        a_pd[0] <= a_mem[a_rd % 16];
        b_pv[0] <= !b_re && (b_wr != b_rd);
        b_pd[0] <= b_mem[b_rd % 16];
        if (!a_re && (a_wr != a_rd)) begin
            a_rd   <= a_rd + 1;
            a_pops <= a_pops + 1;
        end
        if (!b_re && (b_wr != b_rd)) begin
            b_rd   <= b_rd + 1;
            b_pops <= b_pops + 1;
        end
    end

    always @(negedge clk) begin
        if (rst && !a_re && !b_re)
            re_viol <= re_viol + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_a(input logic [15:0] v);
        a_mem[a_wr % 16] = v;
        a_wr = a_wr + 1;
    endtask

    task automatic push_b(input logic [15:0] v);
        b_mem[b_wr % 16] = v;
        b_wr = b_wr + 1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!m_axis_tvalid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 16'(m_axis_tvalid), 16'h1);
    endtask

    // Expects tready = 1: three bytes on consecutive cycles, then tvalid and grant drop.
    task automatic get_pkt(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [1:0] eg);
        wait_valid(tag);
        check({tag, "_grant"}, 16'(grant), 16'(eg));
        check({tag, "_hdr"}, 16'(m_axis_tdata), 16'(e0));
        cyc(1);
        check({tag, "_msb_valid"}, 16'(m_axis_tvalid), 16'h1);
        check({tag, "_msb"}, 16'(m_axis_tdata), 16'(e1));
        cyc(1);
        check({tag, "_lsb_valid"}, 16'(m_axis_tvalid), 16'h1);
        check({tag, "_lsb"}, 16'(m_axis_tdata), 16'(e2));
        cyc(1);
        check({tag, "_end_valid"}, 16'(m_axis_tvalid), 16'h0);
        check({tag, "_end_grant"}, 16'(grant), 16'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst           = 1'b0;
        m_axis_tready = 1'b0;
        tx_busy       = 1'b0;
        cyc(2);

        // Reset state
        check("rst_a_re", 16'(a_re), 16'h1);
        check("rst_b_re", 16'(b_re), 16'h1);
        check("rst_tvalid", 16'(m_axis_tvalid), 16'h0);
        check("rst_tdata", 16'(m_axis_tdata), 16'h0);
        check("rst_grant", 16'(grant), 16'h0);
        check("rst_pkt_count", pkt_count, 16'h0);
        rst = 1'b1;
        cyc(1);

        // Single A packet: one-cycle pop, then A5 12 34
        m_axis_tready = 1'b1;
        push_a(16'h1234);
        cyc(1);
        check("t1_a_re_low", 16'(a_re), 16'h0);
        check("t1_b_re_high", 16'(b_re), 16'h1);
        check("t1_grant", 16'(grant), 16'h1);
        cyc(1);
        check("t1_a_re_released", 16'(a_re), 16'h1);
        get_pkt("t1", 8'hA5, 8'h12, 8'h34, 2'b01);
        check("t1_pkt_count", pkt_count, 16'd1);

        // Tie after reset: A first, then B
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        push_a(16'h0001);
        push_b(16'h0002);
        get_pkt("t2a", 8'hA5, 8'h00, 8'h01, 2'b01);
        get_pkt("t2b", 8'h5A, 8'h00, 8'h02, 2'b10);
        check("t2_pkt_count", pkt_count, 16'd2);

        // Backpressure in MSB for 5 cycles; B arrives mid-packet and must wait
        push_a(16'hABCD);
        wait_valid("t3");
        check("t3_hdr", 16'(m_axis_tdata), 16'hA5);
        cyc(1);
        m_axis_tready = 1'b0;
        push_b(16'h7777);
        check("t3_msb", 16'(m_axis_tdata), 16'hAB);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("t3_hold_valid", 16'(m_axis_tvalid), 16'h1);
            check("t3_hold_tdata", 16'(m_axis_tdata), 16'hAB);
            check("t3_hold_b_re", 16'(b_re), 16'h1);
        end
        m_axis_tready = 1'b1;
        cyc(1);
        check("t3_lsb", 16'(m_axis_tdata), 16'hCD);
        check("t3_lsb_valid", 16'(m_axis_tvalid), 16'h1);
        cyc(1);
        check("t3_end_valid", 16'(m_axis_tvalid), 16'h0);
        check("t3_pkt_count", pkt_count, 16'd3);
        get_pkt("t3b", 8'h5A, 8'h77, 8'h77, 2'b10);
        check("t3b_pkt_count", pkt_count, 16'd4);

        // tx_busy holds the scheduler in IDLE
        tx_busy = 1'b1;
        push_a(16'h5555);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("t4_busy_a_re", 16'(a_re), 16'h1);
            check("t4_busy_grant", 16'(grant), 16'h0);
        end
        tx_busy = 1'b0;
        cyc(1);
        check("t4_read_a_re", 16'(a_re), 16'h0);
        check("t4_read_grant", 16'(grant), 16'h1);
        get_pkt("t4", 8'hA5, 8'h55, 8'h55, 2'b01);
        check("t4_pkt_count", pkt_count, 16'd5);

        // Reset during HDR abandons the packet asynchronously
        m_axis_tready = 1'b0;
        push_a(16'h1111);
        wait_valid("t5");
        check("t5_hdr", 16'(m_axis_tdata), 16'hA5);
        #2;
        rst = 1'b0;
        #1;
        check("t5_async_valid", 16'(m_axis_tvalid), 16'h0);
        check("t5_async_tdata", 16'(m_axis_tdata), 16'h0);
        check("t5_async_pkt_count", pkt_count, 16'h0);
        check("t5_async_grant", 16'(grant), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        push_a(16'h2222);
        m_axis_tready = 1'b1;
        get_pkt("t5", 8'hA5, 8'h22, 8'h22, 2'b01);
        check("t5_pkt_count", pkt_count, 16'd1);

        // Counter wrap from 16'hFFFF
        force dut.pkt_count = 16'hFFFF;
        #1;
        release dut.pkt_count;
        check("t6_preload", pkt_count, 16'hFFFF);
        push_a(16'h0F0F);
        get_pkt("t6", 8'hA5, 8'h0F, 8'h0F, 2'b01);
        check("t6_wrap", pkt_count, 16'h0000);

        // Pop accounting and mutual exclusion of read enables
        cyc(2);
        check("pops_a", 16'(a_pops), 16'd7);
        check("pops_b", 16'(b_pops), 16'd2);
        check("re_both_low", 16'(re_viol), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
